// File: rtl/jts16_colmix_pkg.sv
// jts16_colmix_pkg: shared definitions for the System 16 colour mixer.
//   - palette entry field positions
//   - clear-counter terminal value
//   - controller state enum
//   - shade(): shadow/highlight shading of one 8-bit channel level
package jts16_colmix_pkg;

    localparam int unsigned HL_BIT = 15;
    localparam int unsigned B0_BIT = 14;
    localparam int unsigned G0_BIT = 13;
    localparam int unsigned R0_BIT = 12;
    localparam int unsigned B_HI   = 11;
    localparam int unsigned B_LO   = 8;
    localparam int unsigned G_HI   = 7;
    localparam int unsigned G_LO   = 4;
    localparam int unsigned R_HI   = 3;
    localparam int unsigned R_LO   = 0;

    localparam logic [10:0] CLR_LAST = 11'h7FF;

    typedef enum logic [0:0] {CLEAR, RUN} state_t;

    // 5-bit channel to 8-bit level, replicating the top bits into the LSBs.
    function automatic logic [7:0] expand(input logic [4:0] c5);
        return {c5, c5[4:2]};
    endfunction

    // Shadow wins over highlight. Both results stay within 8 bits.
    function automatic logic [7:0] shade(input logic [7:0] n, input logic sh, input logic hl);
        logic [9:0] x3;
        x3 = {2'b00, n} + {1'b0, n, 1'b0};
        if (sh) begin
            return x3[9:2];
        end else if (hl) begin
            return n + ((8'hFF - n) >> 2);
        end else begin
            return n;
        end
    endfunction

endpackage

// File: rtl/jtframe_dual_ram16.sv
// jtframe_dual_ram16: 2^AW x 16 dual-port RAM, synchronous reads.
//   Port A: read/write with per-byte write enables (we_a[1] upper, we_a[0] lower).
//   Port B: read-only, read enabled by rd_b; dout_b holds between reads.
//   A write and a port-B read of the same address on the same clk return the old data.
module jtframe_dual_ram16 #(
    parameter int unsigned AW = 11
) (
    input  logic          clk,
    input  logic [AW-1:0] addr_a,
    input  logic [15:0]   din_a,
    input  logic [1:0]    we_a,
    output logic [15:0]   dout_a,
    input  logic [AW-1:0] addr_b,
    input  logic          rd_b,
    output logic [15:0]   dout_b
);

    localparam int unsigned DEPTH = 1 << AW;

    logic [15:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we_a[0]) mem[addr_a][7:0]  <= din_a[7:0];
        if (we_a[1]) mem[addr_a][15:8] <= din_a[15:8];
        dout_a <= mem[addr_a];
        if (rd_b) dout_b <= mem[addr_b];
    end

endmodule

// File: rtl/jts16_colmix.sv
// jts16_colmix: final colour stage of the System 16 video path.
//   Looks up pal_addr in a CPU-writable 2048x16 palette, applies shadow/highlight
//   shading and outputs 8-bit RGB with blanking delayed to match (2 pxl_cen ticks).
//   After reset the palette is cleared, one entry per clk, while clr_busy is high.
// Ports:
//   clk, rst (sync, active-high), pxl_cen
//   CPU side : pal_cs, cpu_addr, cpu_dout, dswn (active-low byte strobes), cpu_din
//   Video    : pal_addr, shadow, preLHBL, preLVBL -> LHBL, LVBL, red, green, blue
//   clr_busy : palette clear in progress
// Build option: define JTS16_SHADE_EN for shadow/highlight shading; otherwise the
//   normal level is always output and shadow / entry bit 15 are ignored.
module jts16_colmix
    import jts16_colmix_pkg::*;
#(
    parameter int unsigned PXL_LAT = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        pxl_cen,
    input  logic        pal_cs,
    input  logic [10:0] cpu_addr,
    input  logic [15:0] cpu_dout,
    input  logic [1:0]  dswn,
    output logic [15:0] cpu_din,
    input  logic [10:0] pal_addr,
    input  logic        shadow,
    input  logic        preLHBL,
    input  logic        preLVBL,
    output logic        LHBL,
    output logic        LVBL,
    output logic [7:0]  red,
    output logic [7:0]  green,
    output logic [7:0]  blue,
    output logic        clr_busy
);

    state_t      state_q, state_d;
    logic [10:0] cnt_q, cnt_d;
    logic        clearing;

    logic [10:0] ram_addr_a;
    logic [15:0] ram_din_a, ram_dout_a, ram_dout_b;
    logic [1:0]  ram_we_a;

    logic               shadow_q;
    logic [PXL_LAT-1:0] hbl_sr, vbl_sr;
    logic [7:0]         red_d, green_d, blue_d;

    assign clearing = (state_q == CLEAR);
    assign clr_busy = clearing;

    // Clear controller
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        if (state_q == CLEAR) begin
            cnt_d = cnt_q + 11'd1;
            if (cnt_q == CLR_LAST) state_d = RUN;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= CLEAR;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Port A belongs to the clear counter while clearing, to the CPU otherwise.
    always_comb begin
        ram_addr_a = cpu_addr;
        ram_din_a  = cpu_dout;
        ram_we_a   = pal_cs ? ~dswn : 2'b00;
        if (clearing) begin
            ram_addr_a = cnt_q;
            ram_din_a  = 16'h0000;
            ram_we_a   = 2'b11;
        end
    end

    assign cpu_din = clearing ? 16'h0000 : ram_dout_a;

    // Stage 1 is the RAM's registered read of pal_addr, taken on pxl_cen only so
    // the data seen at the next tick is the one read at this tick.
    jtframe_dual_ram16 #(
        .AW (11)
    ) u_ram (
        .clk    (clk),
        .addr_a (ram_addr_a),
        .din_a  (ram_din_a),
        .we_a   (ram_we_a),
        .dout_a (ram_dout_a),
        .addr_b (pal_addr),
        .rd_b   (pxl_cen),
        .dout_b (ram_dout_b)
    );

    // Stage 2 colour computation
    always_comb begin
        logic [7:0] nr, ng, nb;
        logic       blank;
        nr = expand({ram_dout_b[R_HI:R_LO], ram_dout_b[R0_BIT]});
        ng = expand({ram_dout_b[G_HI:G_LO], ram_dout_b[G0_BIT]});
        nb = expand({ram_dout_b[B_HI:B_LO], ram_dout_b[B0_BIT]});
`ifdef JTS16_SHADE_EN
        red_d   = shade(nr, shadow_q, ram_dout_b[HL_BIT]);
        green_d = shade(ng, shadow_q, ram_dout_b[HL_BIT]);
        blue_d  = shade(nb, shadow_q, ram_dout_b[HL_BIT]);
`else
        red_d   = nr;
        green_d = ng;
        blue_d  = nb;
`endif
        blank = !hbl_sr[PXL_LAT-2] || !vbl_sr[PXL_LAT-2];
        if (clearing || blank) begin
            red_d   = 8'h00;
            green_d = 8'h00;
            blue_d  = 8'h00;
        end
    end

`ifndef JTS16_SHADE_EN
    logic unused_shade;
    assign unused_shade = ^{shadow_q, ram_dout_b[HL_BIT]};
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            shadow_q <= 1'b0;
            hbl_sr   <= '0;
            vbl_sr   <= '0;
            red      <= 8'h00;
            green    <= 8'h00;
            blue     <= 8'h00;
        end else if (pxl_cen) begin
            shadow_q <= shadow;
            hbl_sr   <= {hbl_sr[PXL_LAT-2:0], preLHBL};
            vbl_sr   <= {vbl_sr[PXL_LAT-2:0], preLVBL};
            red      <= red_d;
            green    <= green_d;
            blue     <= blue_d;
        end
    end

    assign LHBL = hbl_sr[PXL_LAT-1];
    assign LVBL = vbl_sr[PXL_LAT-1];

endmodule

// File: tb/tb_jts16_colmix.sv
module tb_jts16_colmix;

    logic        clk = 1'b0;
    logic        rst, pxl_cen, pal_cs, shadow, preLHBL, preLVBL;
    logic [10:0] cpu_addr, pal_addr;
    logic [15:0] cpu_dout, cpu_din;
    logic [1:0]  dswn;
    logic        LHBL, LVBL, clr_busy;
    logic [7:0]  red, green, blue;

    int n_cmp  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    jts16_colmix #(
        .PXL_LAT (2)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .pxl_cen  (pxl_cen),
        .pal_cs   (pal_cs),
        .cpu_addr (cpu_addr),
        .cpu_dout (cpu_dout),
        .dswn     (dswn),
        .cpu_din  (cpu_din),
        .pal_addr (pal_addr),
        .shadow   (shadow),
        .preLHBL  (preLHBL),
        .preLVBL  (preLVBL),
        .LHBL     (LHBL),
        .LVBL     (LVBL),
        .red      (red),
        .green    (green),
        .blue     (blue),
        .clr_busy (clr_busy)
    );

    typedef struct {
        logic [15:0] entry;
        logic        sh;
        logic [7:0]  r, g, b;
    } vec_t;

    vec_t vecs [10];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // All tasks start and end just after a negedge.
    task automatic cpu_write(input logic [10:0] a, input logic [15:0] d, input logic [1:0] s);
        pal_cs = 1'b1; cpu_addr = a; cpu_dout = d; dswn = s;
        @(negedge clk);
        pal_cs = 1'b0; dswn = 2'b11;
    endtask

    task automatic cpu_read(input logic [10:0] a, output logic [15:0] d);
        pal_cs = 1'b1; cpu_addr = a; dswn = 2'b11;
        @(negedge clk);
        d = cpu_din;
        pal_cs = 1'b0;
    endtask

    task automatic tick();
        pxl_cen = 1'b1;
        @(negedge clk);
        pxl_cen = 1'b0;
        @(negedge clk);
    endtask

    task automatic release_and_count(input string name);
        int cnt;
        cnt = 0;
        rst = 1'b0;
        while (clr_busy && cnt < 5000) begin
            cnt++;
            @(negedge clk);
        end
        check(name, cnt, 2048);
    endtask

    task automatic check_rgb(input string name, input logic [7:0] r, input logic [7:0] g,
                             input logic [7:0] b);
        check({name, ".r"}, {24'h0, red}, {24'h0, r});
        check({name, ".g"}, {24'h0, green}, {24'h0, g});
        check({name, ".b"}, {24'h0, blue}, {24'h0, b});
    endtask

    initial begin
        logic [15:0] rd;
        int cnt;

`ifdef JTS16_SHADE_EN
        vecs[0] = '{16'h7FFF, 1'b0, 8'hFF, 8'hFF, 8'hFF};
        vecs[1] = '{16'h7FFF, 1'b1, 8'hBF, 8'hBF, 8'hBF};
        vecs[2] = '{16'h8000, 1'b0, 8'h3F, 8'h3F, 8'h3F};
        vecs[3] = '{16'h0000, 1'b0, 8'h00, 8'h00, 8'h00};
        vecs[4] = '{16'h000F, 1'b0, 8'hF7, 8'h00, 8'h00};
        vecs[5] = '{16'h1001, 1'b0, 8'h18, 8'h00, 8'h00};
        vecs[6] = '{16'h0F00, 1'b1, 8'h00, 8'h00, 8'hB9};
        vecs[7] = '{16'h80F0, 1'b0, 8'h3F, 8'hF9, 8'h3F};
        vecs[8] = '{16'h8000, 1'b1, 8'h00, 8'h00, 8'h00};
        vecs[9] = '{16'h2050, 1'b0, 8'h00, 8'h5A, 8'h00};
`else
        vecs[0] = '{16'h7FFF, 1'b0, 8'hFF, 8'hFF, 8'hFF};
        vecs[1] = '{16'h7FFF, 1'b1, 8'hFF, 8'hFF, 8'hFF};
        vecs[2] = '{16'h8000, 1'b0, 8'h00, 8'h00, 8'h00};
        vecs[3] = '{16'h0000, 1'b0, 8'h00, 8'h00, 8'h00};
        vecs[4] = '{16'h000F, 1'b0, 8'hF7, 8'h00, 8'h00};
        vecs[5] = '{16'h1001, 1'b0, 8'h18, 8'h00, 8'h00};
        vecs[6] = '{16'h0F00, 1'b1, 8'h00, 8'h00, 8'hF7};
        vecs[7] = '{16'h80F0, 1'b0, 8'h00, 8'hF7, 8'h00};
        vecs[8] = '{16'h8000, 1'b1, 8'h00, 8'h00, 8'h00};
        vecs[9] = '{16'h2050, 1'b0, 8'h00, 8'h5A, 8'h00};
`endif

        rst = 1'b1; pxl_cen = 1'b0; pal_cs = 1'b0; cpu_addr = '0; cpu_dout = '0;
        dswn = 2'b11; pal_addr = '0; shadow = 1'b0; preLHBL = 1'b0; preLVBL = 1'b0;
        repeat (3) @(negedge clk);

        // Reset values
        check_rgb("reset_rgb", 8'h00, 8'h00, 8'h00);
        check("reset_lhbl", {31'h0, LHBL}, 32'h0);
        check("reset_lvbl", {31'h0, LVBL}, 32'h0);
        check("reset_cpu_din", {16'h0, cpu_din}, 32'h0);
        check("reset_clr_busy", {31'h0, clr_busy}, 32'h1);

        release_and_count("clear_len_first");
        cpu_read(11'h000, rd); check("read_0x000", {16'h0, rd}, 32'h0);
        cpu_read(11'h7FF, rd); check("read_0x7ff", {16'h0, rd}, 32'h0);

        // Byte lanes
        cpu_write(11'h010, 16'h1234, 2'b00);
        cpu_write(11'h010, 16'hABCD, 2'b10);
        cpu_read(11'h010, rd); check("lane_lower", {16'h0, rd}, 32'h12CD);
        cpu_write(11'h010, 16'h5600, 2'b01);
        cpu_read(11'h010, rd); check("lane_upper", {16'h0, rd}, 32'h56CD);

        // Colour table
        preLHBL = 1'b1; preLVBL = 1'b1;
        for (int i = 0; i < 10; i++) begin
            cpu_write(11'h100 + 11'(i), vecs[i].entry, 2'b00);
            pal_addr = 11'h100 + 11'(i);
            shadow   = vecs[i].sh;
            tick();
            tick();
            check_rgb($sformatf("vec%0d", i), vecs[i].r, vecs[i].g, vecs[i].b);
        end
        check("lhbl_active", {31'h0, LHBL}, 32'h1);
        check("lvbl_active", {31'h0, LVBL}, 32'h1);

        // Same-clk CPU write and video read of entry 0x020
        cpu_write(11'h020, 16'h000F, 2'b00);
        pal_addr = 11'h020; shadow = 1'b0;
        pxl_cen = 1'b1; pal_cs = 1'b1; cpu_addr = 11'h020; cpu_dout = 16'h7FFF; dswn = 2'b00;
        @(negedge clk);
        pxl_cen = 1'b0; pal_cs = 1'b0; dswn = 2'b11;
        @(negedge clk);
        tick();
        check_rgb("collide_old", 8'hF7, 8'h00, 8'h00);
        tick();
        tick();
        check_rgb("collide_new", 8'hFF, 8'hFF, 8'hFF);

        // Horizontal blanking, exactly two ticks of delay
        pal_addr = 11'h100;
        tick(); tick();
        preLHBL = 1'b0;
        tick();
        check("hbl_tick1_lhbl", {31'h0, LHBL}, 32'h1);
        check("hbl_tick1_red", {24'h0, red}, 32'hFF);
        tick();
        check("hbl_tick2_lhbl", {31'h0, LHBL}, 32'h0);
        check_rgb("hbl_tick2", 8'h00, 8'h00, 8'h00);
        preLHBL = 1'b1; preLVBL = 1'b0;
        tick(); tick();
        check("vbl_lvbl", {31'h0, LVBL}, 32'h0);
        check("vbl_lhbl", {31'h0, LHBL}, 32'h1);
        check_rgb("vbl", 8'h00, 8'h00, 8'h00);
        preLVBL = 1'b1;

        // Reset while running
        rst = 1'b1;
        repeat (2) @(negedge clk);
        release_and_count("clear_len_run_reset");
        cpu_read(11'h010, rd); check("cleared_0x010", {16'h0, rd}, 32'h0);

        // Reset in the middle of a clear restarts it from zero
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (100) @(negedge clk);
        check("mid_clear_busy", {31'h0, clr_busy}, 32'h1);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        release_and_count("clear_len_mid_reset");

        // CPU accesses during clear are ignored; blanking still propagates
        cpu_write(11'h123, 16'h1111, 2'b00);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (4) @(negedge clk);
        cpu_write(11'h000, 16'hFFFF, 2'b00);
        cpu_read(11'h123, rd); check("clear_cpu_din", {16'h0, rd}, 32'h0);
        tick(); tick();
        check("clear_lhbl", {31'h0, LHBL}, 32'h1);
        check_rgb("clear_rgb", 8'h00, 8'h00, 8'h00);
        cnt = 0;
        while (clr_busy && cnt < 5000) begin
            cnt++;
            @(negedge clk);
        end
        check("clear_done", {31'h0, clr_busy}, 32'h0);
        cpu_read(11'h000, rd); check("dropped_write", {16'h0, rd}, 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
